// File: rtl/uart_rx_if.sv
// UART receiver bus: tick/serial/line-control inputs and received-word outputs.
// Ports (slave view = receiver):
//   sample_tick  in   16x baud strobe
//   sin          in   asynchronous serial line, idle high
//   word_len     in   00=5, 01=6, 10=7, 11=8 data bits
//   parity_en, even_parity, stick_parity  in  parity controls
//   rx_data      out  received word, right-justified
//   rx_valid     out  one-cycle frame-complete pulse
//   parity_err, framing_err, break_det    out status, valid with rx_valid
//   rx_busy      out  receiver not idle
interface uart_rx_if;
    logic       sample_tick;
    logic       sin;
    logic [1:0] word_len;
    logic       parity_en;
    logic       even_parity;
    logic       stick_parity;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       framing_err;
    logic       break_det;
    logic       rx_busy;

    modport master (
        output sample_tick, sin, word_len, parity_en, even_parity, stick_parity,
        input  rx_data, rx_valid, parity_err, framing_err, break_det, rx_busy
    );

    modport slave (
        input  sample_tick, sin, word_len, parity_en, even_parity, stick_parity,
        output rx_data, rx_valid, parity_err, framing_err, break_det, rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 5-8 data bits, optional/stick parity,
// one checked stop bit, break detection.
// Ports:
//   clk    single clock
//   reset  asynchronous active-low reset
//   bus    uart_rx_if.slave (see interface file for signal list)
// Parameter SYNC_STAGES: flops on sin before use (min 2).
// Optional macro UART_RX_MAJORITY_VOTE_EN: each bit is the 2-of-3 majority of
// the three ticks ending at the sample point instead of a single sample.
module uart_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.slave  bus
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sin_s;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [1:0]          wl_q, wl_d;
    logic                pen_q, pen_d;
    logic                even_q, even_d;
    logic                stick_q, stick_d;
    logic                perr_q, perr_d;
    logic                pbit_q, pbit_d;

    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                pe_q, pe_d;
    logic                fe_q, fe_d;
    logic                bd_q, bd_d;
    logic                busy_q, busy_d;

    logic                bit_val;
    logic [IDX_W-1:0]    last_idx;
    logic                exp_par;

    // Input synchronizer; reset to idle level so no false start after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sin};
        end
    end

    assign sin_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0]       vote_q, vote_d;
    logic [CNT_W-1:0] vote_lo;

    // First two of the three votes; the third is the live sample.
    assign vote_lo = (state_q == START) ? CNT_W'(5) : CNT_W'(13);

    always_comb begin
        vote_d = vote_q;
        if (bus.sample_tick && (state_q != IDLE)) begin
            if (cnt_q == vote_lo) begin
                vote_d[0] = sin_s;
            end
            if (cnt_q == vote_lo + CNT_W'(1)) begin
                vote_d[1] = sin_s;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vote_q <= 2'b11;
        end else begin
            vote_q <= vote_d;
        end
    end

    assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & sin_s) | (vote_q[1] & sin_s);
`else
    assign bit_val = sin_s;
`endif

    assign last_idx = IDX_W'(4) + IDX_W'(wl_q);

    // Parity bit the frame should carry, from the latched controls.
    assign exp_par = stick_q ? ~even_q : ((^shift_q) ^ ~even_q);

    // Next-state and output logic; everything moves only on sample ticks.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        wl_d       = wl_q;
        pen_d      = pen_q;
        even_d     = even_q;
        stick_d    = stick_q;
        perr_d     = perr_q;
        pbit_d     = pbit_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        pe_d       = pe_q;
        fe_d       = fe_q;
        bd_d       = bd_q;

        if (bus.sample_tick) begin
            case (state_q)
                IDLE: begin
                    if (!sin_s) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_W'(7)) begin
                        cnt_d = '0;
                        if (!bit_val) begin
                            state_d = DATA;
                            idx_d   = '0;
                            shift_d = '0;
                            perr_d  = 1'b0;
                            pbit_d  = 1'b0;
                            wl_d    = bus.word_len;
                            pen_d   = bus.parity_en;
                            even_d  = bus.even_parity;
                            stick_d = bus.stick_parity;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_W'(15)) begin
                        cnt_d          = '0;
                        shift_d[idx_q] = bit_val;
                        if (idx_q == last_idx) begin
                            idx_d   = '0;
                            state_d = pen_q ? PARITY : STOP;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (cnt_q == CNT_W'(15)) begin
                        cnt_d   = '0;
                        pbit_d  = bit_val;
                        perr_d  = (bit_val != exp_par);
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_W'(15)) begin
                        cnt_d      = '0;
                        state_d    = IDLE;
                        rx_valid_d = 1'b1;
                        rx_data_d  = shift_q;
                        pe_d       = perr_q;
                        fe_d       = ~bit_val;
                        // Start bit is known low; everything else must be low too.
                        bd_d       = (shift_q == '0) && !pbit_q && !bit_val;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            wl_q       <= '0;
            pen_q      <= 1'b0;
            even_q     <= 1'b0;
            stick_q    <= 1'b0;
            perr_q     <= 1'b0;
            pbit_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            bd_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            wl_q       <= wl_d;
            pen_q      <= pen_d;
            even_q     <= even_d;
            stick_q    <= stick_d;
            perr_q     <= perr_d;
            pbit_q     <= pbit_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            bd_q       <= bd_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.parity_err  = pe_q;
    assign bus.framing_err = fe_q;
    assign bus.break_det   = bd_q;
    assign bus.rx_busy     = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are driven bit by bit, expected
// results queued at send time and compared when rx_valid pulses.
module tb_uart_rx;

    logic clk = 1'b0;
    logic reset;

    uart_rx_if bus ();

    uart_rx #(.SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       bd;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned tick_div = 4;
    int unsigned tick_cnt = 0;
    logic        prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Sample tick generator: one clk wide every tick_div clks (1 = always high).
    always @(negedge clk) begin
        if (tick_cnt >= tick_div - 1) begin
            tick_cnt = 0;
            bus.sample_tick = 1'b1;
        end else begin
            tick_cnt++;
            bus.sample_tick = 1'b0;
        end
    end

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            check("valid_pulse_width", 32'(prev_valid), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rx_data",     bus.rx_data,     mon_e.data);
                check("parity_err",  bus.parity_err,  mon_e.pe);
                check("framing_err", bus.framing_err, mon_e.fe);
                check("break_det",   bus.break_det,   mon_e.bd);
            end
        end
        prev_valid = bus.rx_valid;
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (bus.sample_tick !== 1'b1) @(posedge clk);
        end
    endtask

    task automatic send_bit(input logic b, input int n);
        @(negedge clk);
        bus.sin = b;
        wait_ticks(n);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 0);
    endtask

    // par < 0 sends the correct parity bit. A low stop bit is held for only
    // 9 ticks (sampled at tick offset 8 with continuous ticks) so the line is
    // high again before the receiver looks for the next start bit.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] wl, input logic pen,
                              input logic even, input logic stick, input int par,
                              input logic stop, input bit cfg_glitch);
        int         len;
        logic [7:0] dm;
        logic       ep;
        logic       pb;
        exp_t       e;
        len = 5 + int'(wl);
        dm  = '0;
        for (int i = 0; i < len; i++) dm[i] = d[i];
        ep = stick ? ~even : ((^dm) ^ ~even);
        pb = (par < 0) ? ep : par[0];
        e.data = dm;
        e.pe   = pen && (pb != ep);
        e.fe   = ~stop;
        e.bd   = (dm == 8'h00) && (!pen || !pb) && !stop;
        @(negedge clk);
        bus.word_len     = wl;
        bus.parity_en    = pen;
        bus.even_parity  = even;
        bus.stick_parity = stick;
        exp_q.push_back(e);
        send_bit(1'b0, 16);
        if (cfg_glitch) begin
            @(negedge clk);
            bus.word_len  = ~wl;
            bus.parity_en = ~pen;
        end
        for (int i = 0; i < len; i++) send_bit(dm[i], 16);
        if (pen) send_bit(pb, 16);
        send_bit(stop, stop ? 16 : 9);
        send_bit(1'b1, 32);
        bus.word_len  = wl;
        bus.parity_en = pen;
        wait_drain();
    endtask

    // 8N1 0xFF with a one-tick low glitch in data bit 0; needs tick_div=1.
    // Tick offset g within the bit is seen by the receiver at cnt = g + 7.
    task automatic send_glitch_frame(input int g, input logic [7:0] exp_data);
        exp_t e;
        e.data = exp_data;
        e.pe   = 1'b0;
        e.fe   = 1'b0;
        e.bd   = 1'b0;
        @(negedge clk);
        bus.word_len  = 2'b11;
        bus.parity_en = 1'b0;
        exp_q.push_back(e);
        send_bit(1'b0, 16);
        send_bit(1'b1, g);
        send_bit(1'b0, 1);
        send_bit(1'b1, 15 - g);
        for (int i = 1; i < 8; i++) send_bit(1'b1, 16);
        send_bit(1'b1, 16);
        send_bit(1'b1, 32);
        wait_drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ab;
        reset            = 1'b0;
        bus.sin          = 1'b1;
        bus.word_len     = 2'b11;
        bus.parity_en    = 1'b0;
        bus.even_parity  = 1'b0;
        bus.stick_parity = 1'b0;
        #22;
        check("rst_rx_data",     bus.rx_data,     0);
        check("rst_rx_valid",    bus.rx_valid,    0);
        check("rst_parity_err",  bus.parity_err,  0);
        check("rst_framing_err", bus.framing_err, 0);
        check("rst_break_det",   bus.break_det,   0);
        check("rst_rx_busy",     bus.rx_busy,     0);
        @(negedge clk);
        reset = 1'b1;
        send_bit(1'b1, 32);

        tick_div = 4;
        send_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, -1, 1'b1, 1'b0);
        send_frame(8'h41, 2'b10, 1'b1, 1'b1, 1'b0,  1, 1'b1, 1'b0);
        send_frame(8'h41, 2'b10, 1'b1, 1'b1, 1'b1,  0, 1'b1, 1'b0);
        send_frame(8'h16, 2'b00, 1'b1, 1'b0, 1'b0, -1, 1'b1, 1'b0);
        send_frame(8'h2A, 2'b01, 1'b1, 1'b0, 1'b1,  0, 1'b1, 1'b0);
        send_frame(8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, -1, 1'b1, 1'b1);

        tick_div = 1;
        send_bit(1'b1, 16);
        send_frame(8'hA3, 2'b11, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        send_frame(8'h00, 2'b11, 1'b1, 1'b1, 1'b0,  0, 1'b0, 1'b0);
        send_frame(8'h96, 2'b11, 1'b1, 1'b0, 1'b0, -1, 1'b1, 1'b0);

        // False start: short low pulse, then a good frame.
        tick_div = 4;
        send_bit(1'b1, 16);
        send_bit(1'b0, 4);
        @(negedge clk);
        check("false_start_busy", bus.rx_busy, 1);
        send_bit(1'b1, 16);
        @(negedge clk);
        check("false_start_idle", bus.rx_busy, 0);
        send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, -1, 1'b1, 1'b0);

        // Reset in the middle of data bit 3; partial frame must vanish.
        ab = 8'h5A;
        send_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) send_bit(ab[i], 16);
        send_bit(ab[3], 4);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_rx_data",     bus.rx_data,     0);
        check("midrst_rx_valid",    bus.rx_valid,    0);
        check("midrst_parity_err",  bus.parity_err,  0);
        check("midrst_framing_err", bus.framing_err, 0);
        check("midrst_break_det",   bus.break_det,   0);
        check("midrst_rx_busy",     bus.rx_busy,     0);
        bus.sin = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        send_bit(1'b1, 32);
        send_frame(8'hF0, 2'b11, 1'b0, 1'b0, 1'b0, -1, 1'b1, 1'b0);

        // Single-tick glitch near the sample point of a '1' bit.
        tick_div = 1;
        send_bit(1'b1, 16);
`ifdef UART_RX_MAJORITY_VOTE_EN
        send_glitch_frame(7, 8'hFF);
`else
        send_glitch_frame(8, 8'hFE);
`endif

        repeat (20) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide SYNC_STAGES, default 2, number of flops synchronizing sin (min 2).
Ports (name, direction, width, meaning):
REQ-002 SHALL provide clk  input  1  single clock for all logic.
REQ-003 SHALL provide reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide sample_tick  input  1  one-clk pulse at 16x baud from the baud generator.
REQ-005 SHALL provide sin  input  1  asynchronous serial input, idle high.
REQ-006 SHALL provide word_len  input  2  data bits: 00=5, 01=6, 10=7, 11=8.
REQ-007 SHALL provide parity_en, even_parity, stick_parity  input  1 each  LCR-style parity controls.
REQ-008 SHALL provide rx_data  output  8  received word, right-justified, unused upper bits 0.
REQ-009 SHALL provide rx_valid  output  1  one-clk pulse, frame complete.
REQ-010 SHALL provide parity_err, framing_err, break_det  output  1 each  status, valid only while rx_valid=1.
REQ-011 SHALL provide rx_busy  output  1  high in any state except IDLE.

Function
REQ-012 SHALL pass sin through SYNC_STAGES flops, each reset to 1; all logic below uses the synchronized value sin_s.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; 4-bit tick counter cnt; state and cnt advance only on clk edges where sample_tick=1.
REQ-014 IDLE: on a tick with sin_s=0, SHALL go to START with cnt=0.
REQ-015 START: cnt increments per tick; at cnt=7 the bit SHALL be sampled; 0 -> DATA, cnt=0; 1 -> IDLE (false start, no rx_valid).
REQ-016 SHALL latch word_len, parity_en, even_parity, stick_parity at the START->DATA transition; changes mid-frame have no effect on that frame.
REQ-017 DATA: bit sampled at cnt=15 then cnt=0; LSB first; after the latched word length SHALL go to PARITY if parity_en else STOP.
REQ-018 PARITY: bit sampled at cnt=15; expected = (~even_parity) if stick_parity, else such that XOR(data, parity bit) equals ~even_parity (even: 0, odd: 1); mismatch sets parity_err.
REQ-019 STOP: first stop bit sampled at cnt=15; 0 sets framing_err; then SHALL go to IDLE; only one stop bit is checked.
REQ-020 break_det SHALL be 1 when the start bit, all data bits, the parity bit (if enabled) and the stop bit were all 0; rx_data=0 in that case.
REQ-021 rx_data, parity_err, framing_err, break_det SHALL update, and rx_valid pulse, on the clk edge of the stop-bit sample; the next start edge SHALL be detectable on the following tick.
REQ-022 Flags and rx_data SHALL hold between frames; rx_valid SHALL be 0 except the single completion cycle.
REQ-023 sample_tick continuously high SHALL be legal (one step per clk).

Reset
REQ-024 On reset=0, asynchronously: state=IDLE, cnt=0, synchronizer flops=1, rx_data=0, rx_valid=0, parity_err=0, framing_err=0, break_det=0, rx_busy=0.
REQ-025 Reset mid-frame SHALL discard the partial frame with no rx_valid; first frame after release SHALL be received normally.

Configuration
REQ-026 Macro UART_RX_MAJORITY_VOTE_EN: when defined, each bit value SHALL be the 2-of-3 majority of sin_s on ticks cnt=5,6,7 (START) or cnt=13,14,15 (other states); when undefined, the single sample at cnt=7/cnt=15 SHALL be used; timing identical either way.

Verification
REQ-027 8N1, sample_tick every 4 clk, frame 0x55 -> rx_data=0x55, rx_valid one cycle, all flags 0.
REQ-028 7E1, data 0x41, parity bit 1 (wrong) -> rx_data=0x41, parity_err=1; repeat with stick_parity=1, even_parity=1, parity bit 0 -> parity_err=0.
REQ-029 8N1, 0xA3 with stop bit 0 -> rx_data=0xA3, framing_err=1, break_det=0; all-zero line for 11 bit times with parity_en=1 -> rx_data=0, break_det=1, framing_err=1.
REQ-030 sin low for 4 ticks then high -> returns to IDLE, rx_busy falls, no rx_valid; following 0x3C frame received correctly.
REQ-031 reset asserted during data bit 3 of a frame -> all outputs 0 immediately, no rx_valid; next frame 0xF0 received correctly.
REQ-032 With UART_RX_MAJORITY_VOTE_EN, 1-tick low glitch at cnt=14 of a '1' data bit -> bit received as 1; without macro, glitch at cnt=15 -> bit received as 0.
